// File: rtl/rca_result_accumulator_if.sv
// rca_result_accumulator_if: adder-result stream in (start, in_valid, s_in, cout_in), batch status out (busy, done, acc_out, carry_cnt, ovf)
interface rca_result_accumulator_if #(parameter int WIDTH = 4, parameter int ACC_W = 8);
  logic start;
  logic in_valid;
  logic [WIDTH-1:0] s_in;
  logic cout_in;
  logic busy;
  logic done;
  logic [ACC_W-1:0] acc_out;
  logic [3:0] carry_cnt;
  logic ovf;
  modport master(output start, in_valid, s_in, cout_in, input busy, done, acc_out, carry_cnt, ovf);
  modport slave(input start, in_valid, s_in, cout_in, output busy, done, acc_out, carry_cnt, ovf);
endinterface

// File: rtl/rca_result_accumulator.sv
// rca_result_accumulator: sums NUM_SAMPLES {cout,s} adder results per batch; ports clk, rst, b (slave: start/in_valid/s_in/cout_in in, busy/done/acc_out/carry_cnt/ovf out)
module rca_result_accumulator #(
  parameter int WIDTH = 4,
  parameter int ACC_W = 8,
  parameter int NUM_SAMPLES = 4
) (
  input logic clk,
  input logic rst,
  rca_result_accumulator_if.slave b
);
  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
  state_t state, state_n;
  logic [7:0] cnt;
  logic take, clr, last;
  logic [ACC_W:0] sum;
  always_comb begin
    take = state == ACCUM && b.in_valid;
    clr = state == IDLE && b.start;
    last = take && cnt == 8'(NUM_SAMPLES - 1);
    sum = {1'b0, b.acc_out} + (ACC_W + 1)'({b.cout_in, b.s_in});
    state_n = clr ? ACCUM : last ? DONE : state == DONE ? IDLE : state;
  end
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= state_n;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      b.busy <= 1'b0;
      b.done <= 1'b0;
      b.acc_out <= '0;
      b.carry_cnt <= '0;
      b.ovf <= 1'b0;
    end else begin
      b.busy <= state_n == ACCUM;
      b.done <= state_n == DONE;
      if (clr) begin
        cnt <= '0;
        b.acc_out <= '0;
        b.carry_cnt <= '0;
        b.ovf <= 1'b0;
      end else if (take) begin
        cnt <= cnt + 8'd1;
        b.acc_out <= sum[ACC_W-1:0];
        b.ovf <= b.ovf | sum[ACC_W];
        b.carry_cnt <= b.carry_cnt + 4'(b.cout_in && b.carry_cnt != 4'd15);
      end
    end
  end
endmodule

// File: tb/tb_rca_result_accumulator.sv
// tb_rca_result_accumulator: randomized batches on 4- and 10-sample accumulators against a sum/count reference model
module tb_rca_result_accumulator;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start4 = 1'b0, start10 = 1'b0, in_valid = 1'b0, cout_in = 1'b0;
  logic [3:0] s_in = '0;
  int total = 0, bad = 0;
  logic [4:0] smp[$];
  int last_acc[2], last_cc[2], last_ovf[2];
  rca_result_accumulator_if #(.WIDTH(4), .ACC_W(8)) i4();
  rca_result_accumulator_if #(.WIDTH(4), .ACC_W(8)) i10();
  assign i4.start = start4;
  assign i10.start = start10;
  assign i4.in_valid = in_valid;
  assign i10.in_valid = in_valid;
  assign i4.s_in = s_in;
  assign i10.s_in = s_in;
  assign i4.cout_in = cout_in;
  assign i10.cout_in = cout_in;
  rca_result_accumulator #(.WIDTH(4), .ACC_W(8), .NUM_SAMPLES(4)) dut4(.clk(clk), .rst(rst), .b(i4));
  rca_result_accumulator #(.WIDTH(4), .ACC_W(8), .NUM_SAMPLES(10)) dut10(.clk(clk), .rst(rst), .b(i10));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic check_all(input bit big, input string tag, input int acc, input int cc, input int ovf, input int busy, input int done);
    check({tag, ".acc"}, big ? i10.acc_out : i4.acc_out, acc);
    check({tag, ".cc"}, big ? i10.carry_cnt : i4.carry_cnt, cc);
    check({tag, ".ovf"}, big ? i10.ovf : i4.ovf, ovf);
    check({tag, ".busy"}, big ? i10.busy : i4.busy, busy);
    check({tag, ".done"}, big ? i10.done : i4.done, done);
  endtask
  // poke: 0 plain, 1 start pulse while busy after two samples, 2 reset after two samples
  task automatic run_batch(input bit big, input int maxgap, input int poke, input string tag);
    int n = big ? 10 : 4;
    int sum = 0, cc = 0;
    in_valid = 1'b1;
    {cout_in, s_in} = 5'h1F;
    tick();
    check_all(big, {tag, ".idle"}, last_acc[big], last_cc[big], last_ovf[big], 0, 0);
    if (big) start10 = 1'b1;
    else start4 = 1'b1;
    tick();
    start4 = 1'b0;
    start10 = 1'b0;
    in_valid = 1'b0;
    check_all(big, {tag, ".start"}, 0, 0, 0, 1, 0);
    for (int i = 0; i < n; i++) begin
      if (i == 2 && poke == 1) begin
        if (big) start10 = 1'b1;
        else start4 = 1'b1;
        tick();
        start4 = 1'b0;
        start10 = 1'b0;
        check_all(big, {tag, ".restart"}, sum % 256, cc > 15 ? 15 : cc, sum >= 256, 1, 0);
      end
      if (i == 2 && poke == 2) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
        last_acc = '{0, 0};
        last_cc = '{0, 0};
        last_ovf = '{0, 0};
        for (int k = 0; k < 3; k++) begin
          tick();
          check_all(big, {tag, ".abort"}, 0, 0, 0, 0, 0);
        end
        return;
      end
      repeat ($urandom_range(0, maxgap)) begin
        tick();
        check_all(big, {tag, ".gap"}, sum % 256, cc > 15 ? 15 : cc, sum >= 256, 1, 0);
      end
      {cout_in, s_in} = smp[i];
      in_valid = 1'b1;
      sum += int'(smp[i]);
      cc += int'(smp[i][4]);
      tick();
      in_valid = 1'b0;
      if (i < n - 1) check_all(big, {tag, ".mid"}, sum % 256, cc > 15 ? 15 : cc, sum >= 256, 1, 0);
    end
    last_acc[big] = sum % 256;
    last_cc[big] = cc > 15 ? 15 : cc;
    last_ovf[big] = sum >= 256;
    in_valid = 1'b1;
    {cout_in, s_in} = 5'h0F;
    check_all(big, {tag, ".done"}, last_acc[big], last_cc[big], last_ovf[big], 0, 1);
    tick();
    in_valid = 1'b0;
    check_all(big, {tag, ".after"}, last_acc[big], last_cc[big], last_ovf[big], 0, 0);
  endtask
  task automatic fill_random(input int n);
    smp = {};
    for (int i = 0; i < n; i++) smp.push_back(5'($urandom));
  endtask
  initial begin
    last_acc = '{0, 0};
    last_cc = '{0, 0};
    last_ovf = '{0, 0};
    tick();
    tick();
    check_all(0, "rst4", 0, 0, 0, 0, 0);
    check_all(1, "rst10", 0, 0, 0, 0, 0);
    rst = 1'b0;
    smp = {5'b0_0001, 5'b0_0110, 5'b1_0001, 5'b0_1000};
    run_batch(0, 0, 0, "b2b");
    check("b2b.sum", i4.acc_out, 32'h20);
    run_batch(0, 3, 0, "gaps");
    smp = {};
    repeat (10) smp.push_back(5'h1F);
    run_batch(1, 0, 0, "wrap10");
    check("wrap10.sum", i10.acc_out, 32'h36);
    smp = {};
    repeat (10) smp.push_back(5'h10);
    run_batch(1, 2, 0, "cout10");
    smp = {5'b0_0001, 5'b0_0110, 5'b1_0001, 5'b0_1000};
    run_batch(0, 1, 1, "restart4");
    run_batch(0, 1, 2, "abort4");
    fill_random(10);
    run_batch(1, 2, 1, "restart10");
    run_batch(1, 2, 2, "abort10");
    for (int r = 0; r < 12; r++) begin
      bit big = r[0];
      fill_random(big ? 10 : 4);
      run_batch(big, $urandom_range(0, 3), 0, big ? "rnd10" : "rnd4");
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
